lfsr_req_arb: RTL and testbench

LFSR_REQ_ARB -- requirements
Module: lfsr_req_arb

---
 rtl/lfsr_req_arb.sv | 104 ++++++++++
 tb/tb_lfsr_req_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_req_arb.sv
// Round-robin arbiter for four requesters that hands out bursts of LFSR words.
// The LFSR advances only on cycles where a word is delivered to the granted requester.
module lfsr_req_arb #(
    parameter int unsigned       width    = 12,
    parameter logic [width-1:0]  tap      = 12'b0000_1001_1001,
    parameter int unsigned       maxburst = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic             seed_load,
    input  logic [width-1:0] seed,
    output logic             seed_ack,
    output logic [3:0]       grant,
    output logic             vld,
    output logic [width-1:0] rnd
);

    // Bit 0 always feeds back, whatever the tap mask says about it.
    localparam logic [width-1:0] TapMask = tap | width'(1);

    typedef enum logic {StIdle, StServe} state_e;

    state_e           state_q;
    logic [width-1:0] s_q;
    logic [1:0]       ptr_q;
    logic [1:0]       w_q;
    logic [3:0]       cnt_q;
    logic [3:0]       grant_q;

    logic             fb;
    logic [width-1:0] s_step;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             found;

    always_comb begin
        fb     = ^(s_q & TapMask);
        s_step = {~fb, s_q[width-1:1]};
    end

    // First asserted request at or after the round-robin pointer.
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            ptr_q   <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!seed_load) begin
                        // An all-ones seed would lock the inverted-feedback LFSR.
                        s_q <= (&seed) ? '0 : seed;
                    end else if (|req) begin
                        w_q     <= win;
                        cnt_q   <= '0;
                        ptr_q   <= win + 2'd1;
                        grant_q <= 4'b0001 << win;
                        state_q <= StServe;
                    end
                end
                StServe: begin
                    if (!req[w_q]) begin
                        grant_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        s_q   <= s_step;
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'(maxburst - 1)) begin
                            grant_q <= '0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign vld      = (state_q == StServe) & req[w_q];
    assign seed_ack = reset & (state_q == StIdle) & ~seed_load;
    assign rnd      = s_q;

endmodule

// File: tb/tb_lfsr_req_arb.sv
// Directed bench for lfsr_req_arb: bursts, round-robin order, seeding and reset abort.
module tb_lfsr_req_arb;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic        seed_load;
    logic [11:0] seed;
    logic        seed_ack;
    logic [3:0]  grant;
    logic        vld;
    logic [11:0] rnd;

    int n_vec;
    int n_err;

    lfsr_req_arb dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .seed_load(seed_load),
        .seed     (seed),
        .seed_ack (seed_ack),
        .grant    (grant),
        .vld      (vld),
        .rnd      (rnd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference step for tap 12'b0000_1001_1001: feedback from bits 0, 3, 4, 7.
    function automatic logic [11:0] lfsr_step(input logic [11:0] s);
        logic f;
        f = s[0] ^ s[3] ^ s[4] ^ s[7];
        return {~f, s[11:1]};
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    logic [11:0] exp_rnd [4];
    logic [3:0]  exp_gnt [5];
    logic [11:0] s_m;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        req       = 4'b0000;
        seed_load = 1'b1;
        seed      = 12'h000;
        exp_rnd   = '{12'h000, 12'h800, 12'hC00, 12'hE00};
        exp_gnt   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state, including seed_ack suppressed while in reset
        #1;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_vld", 32'(vld), 32'h0);
        check_eq("rst_rnd", 32'(rnd), 32'h0);
        seed_load = 1'b0;
        #1 check_eq("rst_seed_ack", 32'(seed_ack), 32'h0);
        seed_load = 1'b1;

        // Single requester: 1-cycle latency, 4-word burst, idle gap
        #5 reset = 1'b1;
        req = 4'b0001;
        #1 check_eq("r0_idle_grant", 32'(grant), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("r0_grant", 32'(grant), 32'h1);
            check_eq("r0_vld", 32'(vld), 32'h1);
            check_eq("r0_rnd", 32'(rnd), 32'(exp_rnd[i]));
        end
        @(posedge clk); #1;
        check_eq("r0_gap_grant", 32'(grant), 32'h0);
        check_eq("r0_gap_vld", 32'(vld), 32'h0);
        check_eq("r0_gap_rnd", 32'(rnd), 32'hF00);

        // All requesters: round-robin order with an idle gap between bursts
        do_reset();
        req = 4'b1111;
        s_m = 12'h000;
        #1 check_eq("rr_idle_grant", 32'(grant), 32'h0);
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                check_eq("rr_grant", 32'(grant), 32'(exp_gnt[b]));
                check_eq("rr_vld", 32'(vld), 32'h1);
                check_eq("rr_rnd", 32'(rnd), 32'(s_m));
                s_m = lfsr_step(s_m);
            end
            @(posedge clk); #1;
            check_eq("rr_gap_grant", 32'(grant), 32'h0);
            check_eq("rr_gap_vld", 32'(vld), 32'h0);
        end

        // Seed load in IDLE takes priority over a pending request
        do_reset();
        req       = 4'b0001;
        seed_load = 1'b0;
        seed      = 12'h123;
        #1;
        check_eq("sd_ack", 32'(seed_ack), 32'h1);
        check_eq("sd_no_grant", 32'(grant), 32'h0);
        @(posedge clk); #1;
        seed_load = 1'b1;
        #1;
        check_eq("sd_rnd", 32'(rnd), 32'h123);
        check_eq("sd_ack_off", 32'(seed_ack), 32'h0);
        check_eq("sd_still_idle", 32'(grant), 32'h0);
        @(posedge clk); #1;
        check_eq("sd_w1_grant", 32'(grant), 32'h1);
        check_eq("sd_w1_rnd", 32'(rnd), 32'h123);

        // Dropping req[w] after two words ends the burst with two steps only
        @(posedge clk); #1;
        check_eq("dr_w2_vld", 32'(vld), 32'h1);
        check_eq("dr_w2_rnd", 32'(rnd), 32'h091);
        @(posedge clk); #1;
        req = 4'b0000;
        #1;
        check_eq("dr_vld_off", 32'(vld), 32'h0);
        check_eq("dr_grant_held", 32'(grant), 32'h1);
        @(posedge clk); #1;
        check_eq("dr_grant_off", 32'(grant), 32'h0);
        check_eq("dr_rnd", 32'(rnd), 32'h048);

        // All-ones seed is replaced by zero
        seed_load = 1'b0;
        seed      = 12'hFFF;
        #1 check_eq("ff_ack", 32'(seed_ack), 32'h1);
        @(posedge clk); #1;
        seed_load = 1'b1;
        #1 check_eq("ff_rnd", 32'(rnd), 32'h000);

        // Seed request during SERVE waits for the first IDLE cycle
        req = 4'b0001;
        @(posedge clk); #1;
        check_eq("sv_c1_grant", 32'(grant), 32'h1);
        @(posedge clk); #1;
        seed_load = 1'b0;
        seed      = 12'h5A5;
        #1 check_eq("sv_c2_ack", 32'(seed_ack), 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check_eq("sv_ack_off", 32'(seed_ack), 32'h0);
            check_eq("sv_grant", 32'(grant), 32'h1);
        end
        @(posedge clk); #1;
        check_eq("sv_idle_ack", 32'(seed_ack), 32'h1);
        check_eq("sv_idle_grant", 32'(grant), 32'h0);
        check_eq("sv_old_rnd", 32'(rnd), 32'hF00);
        @(posedge clk); #1;
        seed_load = 1'b1;
        #1;
        check_eq("sv_rnd", 32'(rnd), 32'h5A5);
        check_eq("sv_ack_done", 32'(seed_ack), 32'h0);

        // Reset mid-burst clears outputs asynchronously
        @(posedge clk); #1;
        check_eq("ab_grant", 32'(grant), 32'h1);
        @(posedge clk); #1;
        check_eq("ab_rnd_stepped", 32'(rnd), 32'(lfsr_step(12'h5A5)));
        #1 reset = 1'b0;
        #1;
        check_eq("ab_grant_off", 32'(grant), 32'h0);
        check_eq("ab_vld_off", 32'(vld), 32'h0);
        check_eq("ab_rnd_zero", 32'(rnd), 32'h0);
        req   = 4'b0000;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("ab_stay_idle", 32'(grant), 32'h0);
        check_eq("ab_rnd_held", 32'(rnd), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
